// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared debounce state encoding and default stability window
package button_pkg;

   localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

   typedef enum logic [1:0] {
      S_LOW  = 2'b00,
      S_RISE = 2'b01,
      S_HIGH = 2'b10,
      S_FALL = 2'b11
   } db_state_e;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for asynchronous single-bit board inputs
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic ff1_q;
   logic ff1_d;
   logic s_q;
   logic s_d;

   always_comb begin
      ff1_d = d;
      s_d   = ff1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1_q <= 1'b0;
         s_q   <= 1'b0;
      end else begin
         ff1_q <= ff1_d;
         s_q   <= s_d;
      end
   end

   assign q = s_q;

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button debouncer: level changes only after STABLE_CYCLES steady samples
module button_debounce
   import button_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_db,
   output logic btn_busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s;
   db_state_e        state_q;
   db_state_e        state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   sync2 u_sync2 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn_raw),
      .q     (s)
   );

   // Any disagreeing sample aborts a window back to the old stable level.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_LOW: begin
            if (s) begin
               state_d = S_RISE;
               cnt_d   = '0;
            end
         end
         S_RISE: begin
            if (!s) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (!s) begin
               state_d = S_FALL;
               cnt_d   = '0;
            end
         end
         S_FALL: begin
            if (s) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_db   = (state_q == S_HIGH) | (state_q == S_FALL);
   assign btn_busy = (state_q == S_RISE) | (state_q == S_FALL);

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce with STABLE_CYCLES = 4
module tb_button_debounce;
   import button_pkg::*;

   logic clk;
   logic rst_n;
   logic btn_raw;
   logic btn_db;
   logic btn_busy;

   int checks;
   int errors;

   button_debounce #(.STABLE_CYCLES(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw),
      .btn_db   (btn_db),
      .btn_busy (btn_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_low(input int n);
      btn_raw = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      btn_raw = 1'b1;
      rst_n   = 1'b0;
      #2;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (btn_db !== 1'b0 || btn_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold %0d: db=%b busy=%b expected 0/0", i, btn_db, btn_busy);
         end
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int t = 1; t <= 7; t++) begin
         tick();
         checks++;
         if (btn_db !== (t == 7)) begin
            errors++;
            $display("FAIL reset_release_db edge %0d: got %b expected %b", t, btn_db, (t == 7));
         end
      end
   endtask

   task automatic test_clean_press();
      idle_low(10);
      checks++;
      if (btn_db !== 1'b0 || btn_busy !== 1'b0) begin
         errors++;
         $display("FAIL press_idle: db=%b busy=%b expected 0/0", btn_db, btn_busy);
      end
      btn_raw = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         checks++;
         if (btn_db !== (t >= 7) || btn_busy !== (t >= 3 && t <= 6)) begin
            errors++;
            $display("FAIL press edge %0d: db=%b busy=%b expected %b/%b",
                     t, btn_db, btn_busy, (t >= 7), (t >= 3 && t <= 6));
         end
      end
      btn_raw = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         checks++;
         if (btn_db !== (t < 7) || btn_busy !== (t >= 3 && t <= 6)) begin
            errors++;
            $display("FAIL release edge %0d: db=%b busy=%b expected %b/%b",
                     t, btn_db, btn_busy, (t < 7), (t >= 3 && t <= 6));
         end
      end
   endtask

   task automatic test_bounce();
      bit raw_seq  [13] = '{1,0,1,1,0,1,1,1,1,1,1,1,1};
      bit exp_busy [13] = '{0,0,1,0,1,1,0,1,1,1,1,0,0};
      bit exp_db   [13] = '{0,0,0,0,0,0,0,0,0,0,0,1,1};
      idle_low(10);
      for (int t = 0; t < 13; t++) begin
         btn_raw = raw_seq[t];
         tick();
         checks++;
         if (btn_db !== exp_db[t] || btn_busy !== exp_busy[t]) begin
            errors++;
            $display("FAIL bounce edge %0d: db=%b busy=%b expected %b/%b",
                     t + 1, btn_db, btn_busy, exp_db[t], exp_busy[t]);
         end
      end
      idle_low(12);
   endtask

   task automatic test_short_glitch();
      idle_low(10);
      for (int t = 1; t <= 12; t++) begin
         btn_raw = (t <= 4);
         tick();
         checks++;
         if (btn_db !== 1'b0 || btn_busy !== (t >= 3 && t <= 6)) begin
            errors++;
            $display("FAIL glitch edge %0d: db=%b busy=%b expected 0/%b",
                     t, btn_db, btn_busy, (t >= 3 && t <= 6));
         end
      end
   endtask

   task automatic test_reset_mid_window();
      idle_low(10);
      btn_raw = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      btn_raw = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (btn_db !== 1'b1 || btn_busy !== 1'b1) begin
         errors++;
         $display("FAIL in_fall: db=%b busy=%b expected 1/1", btn_db, btn_busy);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (btn_db !== 1'b0 || btn_busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: db=%b busy=%b expected 0/0", btn_db, btn_busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (dut.state_q !== S_LOW || btn_db !== 1'b0) begin
         errors++;
         $display("FAIL after_reset state=%b db=%b expected %b/0", dut.state_q, btn_db, S_LOW);
      end
   endtask

   task automatic test_chained_oneshot();
      int   shots;
      int   width;
      int   max_width;
      logic prev_db;
      logic shot;
      bit   rel_seq [6] = '{0,1,0,0,1,0};
      shots = 0; width = 0; max_width = 0;
      idle_low(10);
      prev_db = btn_db;
      btn_raw = 1'b1;
      for (int t = 0; t < 20; t++) begin
         tick();
         shot    = btn_db & ~prev_db;
         prev_db = btn_db;
         if (shot) begin shots++; width++; end else width = 0;
         if (width > max_width) max_width = width;
      end
      for (int t = 0; t < 20; t++) begin
         btn_raw = (t < 6) ? rel_seq[t] : 1'b0;
         tick();
         shot    = btn_db & ~prev_db;
         prev_db = btn_db;
         if (shot) begin shots++; width++; end else width = 0;
         if (width > max_width) max_width = width;
      end
      checks++;
      if (shots !== 1 || max_width !== 1) begin
         errors++;
         $display("FAIL oneshot: shots=%0d width=%0d expected 1/1", shots, max_width);
      end
      checks++;
      if (btn_db !== 1'b0 || btn_busy !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_end: db=%b busy=%b expected 0/0", btn_db, btn_busy);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      btn_raw = 1'b0;
      rst_n   = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_short_glitch();
      test_reset_mid_window();
      test_chained_oneshot();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
